conv_mem_write_ctrl: RTL

Parametrised write-side address sequencer for convolution-layer output memories. It replaces the per-layer fixed-size counters: one instance, sized by parameters, walks an IMG_W×IMG_H output image once per channel. It issues one write strobe per pixel after a programmable number of accumulate cycles, and reports completion through a start/busy/done handshake. It sits between the convolution MAC datapath and the layer's output RAM.

---
 rtl/conv_mem_write_ctrl_if.sv | 24 ++
 rtl/conv_mem_write_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/conv_mem_write_ctrl_if.sv
// Handshake/bus bundle between the MAC sequencer and its output-RAM write port.
// The controller connects through the slave modport; its driver uses master.
interface conv_mem_write_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int CH_W   = 2
);
  logic              start;
  logic              enable;
  logic [ADDR_W-1:0] addr;
  logic [CH_W-1:0]   chan;
  logic              wr_en;
  logic              busy;
  logic              done;

  modport master (
    output start, enable,
    input  addr, chan, wr_en, busy, done
  );

  modport slave (
    input  start, enable,
    output addr, chan, wr_en, busy, done
  );
endinterface

// File: rtl/conv_mem_write_ctrl.sv
// Write-side address sequencer: walks IMG_W x IMG_H pixels per channel, one strobe per pixel.
// Define CONV_MEM_WR_FLAT_ADDR_EN for a flat chan*IMG_W*IMG_H + pix address.
//
// state | meaning
// IDLE  | reset / waiting for start
// DELAY | counting START_DELAY enabled cycles
// RUN   | accumulate, pixel and channel counters advancing
// DONE  | pass complete, done held until next start
module conv_mem_write_ctrl #(
  parameter int IMG_W          = 8,
  parameter int IMG_H          = 8,
  parameter int CHANNELS       = 3,
  parameter int CYCLES_PER_PIX = 25,
  parameter int START_DELAY    = 1
) (
  input logic                 clk,
  input logic                 reset_n,
  conv_mem_write_ctrl_if.slave bus
);
  localparam int PIX_N = IMG_W * IMG_H;
  localparam int PIX_W = (PIX_N > 1) ? $clog2(PIX_N) : 1;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
`ifdef CONV_MEM_WR_FLAT_ADDR_EN
  localparam int ADDR_W = (PIX_N * CHANNELS > 1) ? $clog2(PIX_N * CHANNELS) : 1;
`else
  localparam int ADDR_W = PIX_W;
`endif
  localparam int CYC_W = (CYCLES_PER_PIX > 1) ? $clog2(CYCLES_PER_PIX) : 1;
  localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLES_PER_PIX - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_N - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);

  typedef enum logic [1:0] {IDLE, DELAY, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CYC_W-1:0] cyc_cnt, cyc_nx;
  logic [PIX_W-1:0] pix, pix_nx;
  logic [CH_W-1:0]  chan_q, chan_nx;
  logic [DLY_W-1:0] dly_cnt, dly_nx;
  logic             pix_end;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      pix     <= '0;
      chan_q  <= '0;
      dly_cnt <= '0;
    end else begin
      state   <= state_nx;
      cyc_cnt <= cyc_nx;
      pix     <= pix_nx;
      chan_q  <= chan_nx;
      dly_cnt <= dly_nx;
    end
  end

  assign pix_end = (cyc_cnt == CYC_LAST);

  always_comb begin
    state_nx = state;
    cyc_nx   = cyc_cnt;
    pix_nx   = pix;
    chan_nx  = chan_q;
    dly_nx   = dly_cnt;
    case (state)
      IDLE, DONE: begin
        // start is deliberately not qualified by enable
        if (bus.start) begin
          state_nx = (START_DELAY == 0) ? RUN : DELAY;
          cyc_nx   = '0;
          pix_nx   = '0;
          chan_nx  = '0;
          dly_nx   = '0;
        end
      end
      DELAY: begin
        if (bus.enable) begin
          if (dly_cnt == DLY_LAST) state_nx = RUN;
          else                     dly_nx   = dly_cnt + 1'b1;
        end
      end
      RUN: begin
        if (bus.enable) begin
          if (pix_end) begin
            cyc_nx = '0;
            if (pix == PIX_LAST) begin
              // final pixel of final channel: hold pix/chan, leave for DONE
              if (chan_q == CH_LAST) begin
                state_nx = DONE;
              end else begin
                pix_nx  = '0;
                chan_nx = chan_q + 1'b1;
              end
            end else begin
              pix_nx = pix + 1'b1;
            end
          end else begin
            cyc_nx = cyc_cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef CONV_MEM_WR_FLAT_ADDR_EN
  localparam logic [ADDR_W-1:0] PIX_N_A = ADDR_W'(PIX_N);
  assign bus.addr = ADDR_W'(chan_q) * PIX_N_A + ADDR_W'(pix);
`else
  assign bus.addr = pix;
`endif

  assign bus.chan  = chan_q;
  assign bus.wr_en = (state == RUN) && bus.enable && pix_end;
  assign bus.busy  = (state == DELAY) || (state == RUN);
  assign bus.done  = (state == DONE);
endmodule
